sd_cmd_arbiter: RTL
===================

# sd_cmd_arbiter

SPI-mode SD command controller shared between two requesters: typically the power-up init sequencer (port 0) and the block-read engine (port 1). Grants the single SD SPI bus round-robin, serialises one 48-bit command, polls for the response start bit, captures an R1 or R7 response, and returns it to the granted requester with a one-cycle done strobe. It owns `SCLK`, `CS_bit` and `MOSI_bit` toward the card pins.

## Interface
- `CLK_DIV`, default 100: half-period of SCLK in `input_clk` cycles, ≥1. 50 MHz / 200 = 250 kHz.
- `NCR_MAX`, default 64: maximum SCLK bits polled for the response start bit.
- `input_clk` in 1: single clock, all logic on the rising edge.
- `input_rst_n` in 1: asynchronous, active-low reset.
- `req` in 2: per-requester request level; held until the matching `done`.
- `req_cmd` in 2x48: packed command per requester, including CRC byte, transmitted MSB first.
- `req_long` in 2: 0 = R1 (8-bit response), 1 = R7 (40-bit response).
- `gnt` out 2: one-hot grant, high from grant until `done`.
- `done` out 2: one-cycle pulse to the owning requester at transaction end.
- `resp` out 40: captured response, valid with `done`. R1 occupies [7:0] with [39:8] = 0. R7 occupies [39:0].
- `timeout` out 1: valid with `done`; 1 = no start bit within `NCR_MAX` bits.
- `SCLK` out 1: SPI mode 0 clock, idles low.
- `CS_bit` out 1: active-low chip select.
- `MOSI_bit` out 1: data to card.
- `MISO_bit` in 1: data from card; sampled on the SCLK rising edge.

## Operation
- States and transitions:
  - IDLE → GRANT when `req != 0`.
  - GRANT (1 cycle) → PRE.
  - PRE (8 bits) → SEND.
  - SEND (48 bits) → WAIT_RESP.
  - WAIT_RESP → RECV on the first sampled 0. WAIT_RESP → POST after `NCR_MAX` ones.
  - RECV (7 or 39 further bits) → POST.
  - POST (8 bits) → DONE.
  - DONE (1 cycle) → IDLE.
- Arbitration in IDLE:
  - If only one requester is asserting, it wins.
  - If both are asserting, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
- GRANT latches `req_cmd`/`req_long` of the winner and asserts `gnt`. Later changes on request inputs are ignored until DONE.
- Dropping `req` mid-transaction does not abort: the transaction completes and `done` still pulses.
- Pin behaviour by state:
  - PRE and POST: `CS_bit`=0, `MOSI_bit`=1.
  - SEND: `CS_bit`=0, `MOSI_bit`=shift[47], left shift once per bit.
  - WAIT_RESP and RECV: `CS_bit`=0, `MOSI_bit`=1.
  - IDLE, GRANT and DONE: `CS_bit`=1, `MOSI_bit`=1, `SCLK` low.
- Response capture:
  - The start bit (0) is resp bit 7 (R1) or bit 39 (R7).
  - Subsequent bits shift in MSB-first.
- Timeout: `resp` = 40'h00_0000_00FF (R1) or 40'hFF_FFFF_FFFF (R7), `timeout`=1.
- DONE: `gnt` drops, `done[winner]`=1, and the last-grant pointer updates.

## Timing
- One SPI bit = 2×`CLK_DIV` `input_clk` cycles.
- SCLK low phase is `CLK_DIV` cycles, then high phase is `CLK_DIV` cycles.
- `MOSI_bit` changes on the cycle SCLK falls, or on entry to the bit's low phase.
- `MISO_bit` is sampled on the cycle SCLK rises.
- The bit counter advances at the end of each high phase.
- `gnt` rises 1 cycle after `req` is seen in IDLE. PRE starts the following cycle.
- Latency, `req` to `done`, with the start bit on poll k (1-based):
  - R1: 1 + 1 + (8+48+k+7+8)×2×`CLK_DIV` + 1 cycles.
  - R7: the same with 39 replacing 7.
- A new grant can occur on the cycle after DONE, so back-to-back transactions are separated by ≥1 IDLE cycle with `CS_bit` high.
- Reset values: `SCLK`=0, `CS_bit`=1, `MOSI_bit`=1, `gnt`=0, `done`=0, `resp`=0, `timeout`=0, state=IDLE, pointer=1.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). No `done` is emitted.

## Structure
- Package `sd_pkg` holds:
  - the state enum;
  - command constants CMD0=48'h400000000095, CMD8=48'h48000001AA87, CMD55=48'h7700000000FF, CMD41=48'h6940000000FF;
  - the R1/R7 length constants (8, 40);
  - the default `NCR_MAX`.
- Sub-module `sd_sclk_gen` provides the `CLK_DIV` counter and generates `SCLK` plus single-cycle `rise_stb` and `fall_stb`. It is enabled only outside IDLE, GRANT and DONE.

## Test plan
- Test conditions: `CLK_DIV`=2 throughout; the card model answers R1 8'h01 on poll 2.
- Single R1: requester 0 sends CMD0. Required response: 48 MOSI bits match 0x400000000095, `resp`=40'h01, `timeout`=0, `done[0]` high for 1 cycle, latency = 1+1+(8+48+2+7+8)×4+1 = 295.
- R7: requester 1 sends CMD8 with `req_long`=1 and the model returns 40'h01_000001AA. Required response: `resp`=40'h01000001AA, `done[1]`.
- Contention: both `req` high from reset. Required response: requester 0 is served, then requester 1, then requester 0 again, with `CS_bit` high ≥1 cycle between transactions.
- Timeout: MISO held 1. Required response: after 64 poll bits `timeout`=1 and `resp`=40'hFF, and the POST 8 bits occur before `done`.
- Reset mid-SEND: `input_rst_n` pulled low at bit 20. Required response: `CS_bit`=1, `SCLK`=0, `gnt`=0 within the same cycle, no `done`; after release, a fresh request completes normally.
- Request drop: `req[0]` deasserted during WAIT_RESP. Required response: the transaction completes and `done[0]` still pulses.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared types and constants for the SPI-mode SD command
//                arbiter: FSM state encoding, standard commands, response
//                lengths and the default response-poll limit.
//  Revision    : 1.0  initial release
// ============================================================================
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_PRE       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_RECV      = 3'd5,
        ST_POST      = 3'd6,
        ST_DONE      = 3'd7
    } sd_state_t;

    // Standard commands, CRC byte included, transmitted MSB first
    localparam logic [47:0] c_CMD0  = 48'h400000000095;
    localparam logic [47:0] c_CMD8  = 48'h48000001AA87;
    localparam logic [47:0] c_CMD55 = 48'h7700000000FF;
    localparam logic [47:0] c_CMD41 = 48'h6940000000FF;

    localparam int c_R1_LEN          = 8;
    localparam int c_R7_LEN          = 40;
    localparam int c_CMD_BITS        = 48;
    localparam int c_PRE_BITS        = 8;
    localparam int c_POST_BITS       = 8;
    localparam int c_NCR_MAX_DEFAULT = 64;

    // Response reported when the card never produced a start bit
    function automatic logic [c_R7_LEN-1:0] timeout_resp(input logic is_long);
        return is_long ? {c_R7_LEN{1'b1}} : 40'h00_0000_00FF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_arbiter_if
//  Description : Two-port requester bus of the SD command arbiter. The
//                requesters use the master modport, the arbiter the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface sd_cmd_arbiter_if;
    import sd_pkg::*;

    logic [1:0]                  req;
    logic [1:0][c_CMD_BITS-1:0]  req_cmd;
    logic [1:0]                  req_long;
    logic [1:0]                  gnt;
    logic [1:0]                  done;
    logic [c_R7_LEN-1:0]         resp;
    logic                        timeout;

    modport master (
        output req, req_cmd, req_long,
        input  gnt, done, resp, timeout
    );

    modport slave (
        input  req, req_cmd, req_long,
        output gnt, done, resp, timeout
    );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_arbiter_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sd_sclk_gen
//  Description : SPI mode-0 clock generator. Each bit is CLK_DIV cycles low
//                followed by CLK_DIV cycles high. The strobes are high on the
//                cycle whose closing edge makes SCLK rise or fall.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_sclk_gen #(
    parameter int CLK_DIV = 100
) (
    input  logic input_clk,
    input  logic input_rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_stb,
    output logic o_fall_stb
);
    localparam int c_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_sclk;
    logic            w_wrap;

    assign w_wrap     = i_en && (r_cnt == c_LAST);
    assign o_rise_stb = w_wrap && !r_sclk;
    assign o_fall_stb = w_wrap &&  r_sclk;
    assign o_sclk     = r_sclk;

    // Half-period counter; held at the start of a low phase while disabled
    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + c_CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_cmd_arbiter
//  Description : Round-robin arbiter and SPI-mode SD command engine for two
//                requesters. Sends one 48-bit command, polls for the response
//                start bit, captures an R1/R7 response and returns it with a
//                one-cycle done strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module sd_cmd_arbiter
    import sd_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int NCR_MAX = c_NCR_MAX_DEFAULT
) (
    input  logic            input_clk,
    input  logic            input_rst_n,
    sd_cmd_arbiter_if.slave bus,
    output logic            SCLK,
    output logic            CS_bit,
    output logic            MOSI_bit,
    input  logic            MISO_bit
);
    localparam int c_CNT_W = ($clog2(NCR_MAX) > 6) ? $clog2(NCR_MAX) : 6;
    localparam logic [c_CNT_W-1:0] c_PRE_LAST  = c_CNT_W'(c_PRE_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_SEND_LAST = c_CNT_W'(c_CMD_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_POLL_LAST = c_CNT_W'(NCR_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_POST_LAST = c_CNT_W'(c_POST_BITS - 1);
    // The start bit is consumed in WAIT_RESP, so RECV takes length-1 bits
    localparam logic [c_CNT_W-1:0] c_R1_LAST   = c_CNT_W'(c_R1_LEN - 2);
    localparam logic [c_CNT_W-1:0] c_R7_LAST   = c_CNT_W'(c_R7_LEN - 2);

    sd_state_t             r_state;
    logic                  r_last;
    logic                  r_win;
    logic [c_CMD_BITS-1:0] r_cmd;
    logic                  r_long;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_miso;
    logic [c_R7_LEN-1:0]   r_rsp;
    logic                  r_to;
    logic [1:0]            r_gnt;
    logic [1:0]            r_done;
    logic [c_R7_LEN-1:0]   r_resp;
    logic                  r_timeout;
    logic                  r_cs;
    logic                  r_mosi;

    logic                  w_en;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_sclk;
    logic                  w_pick;
    logic [c_CNT_W-1:0]    w_recv_last;

    // SCLK runs only while the card is selected
    assign w_en = (r_state != ST_IDLE) && (r_state != ST_GRANT) && (r_state != ST_DONE);

    // On a tie the requester not served last wins
    assign w_pick = (bus.req == 2'b10) ? 1'b1 :
                    (bus.req == 2'b11) ? ~r_last : 1'b0;

    assign w_recv_last = r_long ? c_R7_LAST : c_R1_LAST;

    sd_sclk_gen #(
        .CLK_DIV     (CLK_DIV)
    ) u_sclk_gen (
        .input_clk   (input_clk),
        .input_rst_n (input_rst_n),
        .i_en        (w_en),
        .o_sclk      (w_sclk),
        .o_rise_stb  (w_rise),
        .o_fall_stb  (w_fall)
    );

    assign SCLK        = w_sclk;
    assign CS_bit      = r_cs;
    assign MOSI_bit    = r_mosi;
    assign bus.gnt     = r_gnt;
    assign bus.done    = r_done;
    assign bus.resp    = r_resp;
    assign bus.timeout = r_timeout;

    // Transaction FSM: every state advance happens at the end of a bit
    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_win     <= 1'b0;
            r_cmd     <= '0;
            r_long    <= 1'b0;
            r_cnt     <= '0;
            r_miso    <= 1'b1;
            r_rsp     <= '0;
            r_to      <= 1'b0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_resp    <= '0;
            r_timeout <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b1;
        end else begin
            r_done <= 2'b00;
            if (w_rise) begin
                r_miso <= MISO_bit;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.req != 2'b00) begin
                        r_win   <= w_pick;
                        r_cmd   <= bus.req_cmd[w_pick];
                        r_long  <= bus.req_long[w_pick];
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_cnt   <= '0;
                    r_to    <= 1'b0;
                    r_cs    <= 1'b0;
                    r_mosi  <= 1'b1;
                    r_state <= ST_PRE;
                end
                ST_PRE: begin
                    if (w_fall) begin
                        if (r_cnt == c_PRE_LAST) begin
                            r_cnt   <= '0;
                            r_mosi  <= r_cmd[c_CMD_BITS-1];
                            r_state <= ST_SEND;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (w_fall) begin
                        if (r_cnt == c_SEND_LAST) begin
                            r_cnt   <= '0;
                            r_mosi  <= 1'b1;
                            r_state <= ST_WAIT_RESP;
                        end else begin
                            r_cnt  <= r_cnt + c_CNT_W'(1);
                            r_cmd  <= {r_cmd[c_CMD_BITS-2:0], 1'b0};
                            r_mosi <= r_cmd[c_CMD_BITS-2];
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (w_fall) begin
                        if (!r_miso) begin
                            // Start bit lands in bit 0 and is shifted up to the MSB
                            r_cnt   <= '0;
                            r_rsp   <= '0;
                            r_state <= ST_RECV;
                        end else if (r_cnt == c_POLL_LAST) begin
                            r_cnt   <= '0;
                            r_rsp   <= timeout_resp(r_long);
                            r_to    <= 1'b1;
                            r_state <= ST_POST;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                ST_RECV: begin
                    if (w_fall) begin
                        r_rsp <= {r_rsp[c_R7_LEN-2:0], r_miso};
                        if (r_cnt == w_recv_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_POST;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                ST_POST: begin
                    if (w_fall) begin
                        if (r_cnt == c_POST_LAST) begin
                            r_cnt     <= '0;
                            r_cs      <= 1'b1;
                            r_gnt     <= 2'b00;
                            r_done    <= r_win ? 2'b10 : 2'b01;
                            r_resp    <= r_rsp;
                            r_timeout <= r_to;
                            r_state   <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_last  <= r_win;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
